// File: rtl/instr_encoder.sv
// RISC-V instruction word encoder: turns a field-level request into one encoded
// word (or a LUI/ADDI pair for the LI pseudo-op) behind a valid/ready output slot.
module instr_encoder #(
  parameter bit LI_COMPRESS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_func3,
  input  logic [6:0]  in_func7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        error
);

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {IDLE, EMIT, EMIT2} state_t;

  state_t      state, state_n;
  logic [31:0] pend_instr;
  logic [31:0] word0, word1;
  logic [31:0] li_sum;
  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic        two_word, bad, accept, is_shift;

  // Encode the request as presented; only the accepted one is captured.
  always_comb begin
    word0    = '0;
    word1    = '0;
    two_word = 1'b0;
    bad      = 1'b0;
    li_sum   = in_imm + 32'h0000_0800;
    li_hi    = li_sum[31:12];
    li_lo    = in_imm[11:0];
    is_shift = (in_opcode == OP_IMM) && (in_func3 == 3'b001 || in_func3 == 3'b101);
    case (in_fmt)
      3'd0: word0 = {in_func7, in_rs2, in_rs1, in_func3, in_rd, in_opcode};
      3'd1: begin
        if (is_shift) word0 = {in_func7, in_imm[4:0], in_rs1, in_func3, in_rd, in_opcode};
        else          word0 = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode};
      end
      3'd2: word0 = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], in_opcode};
      3'd3: begin
        word0 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                 in_imm[4:1], in_imm[11], in_opcode};
        bad   = in_imm[0];
      end
      3'd4: word0 = {in_imm[31:12], in_rd, in_opcode};
      3'd5: begin
        word0 = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        bad   = in_imm[0];
      end
      3'd6: begin
        // HI carries the +0x800 so the sign-extended ADDI low part lands exactly.
        if (LI_COMPRESS && li_hi == 20'd0) begin
          word0 = {li_lo, 5'd0, 3'b000, in_rd, OP_IMM};
        end else if (LI_COMPRESS && li_lo == 12'd0) begin
          word0 = {li_hi, in_rd, OP_LUI};
        end else begin
          word0    = {li_hi, in_rd, OP_LUI};
          word1    = {li_lo, in_rd, 3'b000, in_rd, OP_IMM};
          two_word = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    in_ready = !reset && (state == IDLE || (state == EMIT && out_last && out_ready));
    accept   = in_valid && in_ready;
    state_n  = state;
    case (state)
      IDLE:  if (accept && !bad) state_n = EMIT;
      EMIT: begin
        if (out_ready) begin
          if (!out_last)           state_n = EMIT2;
          else if (accept && !bad) state_n = EMIT;
          else                     state_n = IDLE;
        end
      end
      EMIT2:   state_n = EMIT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_last   <= 1'b0;
      error      <= 1'b0;
      pend_instr <= '0;
    end else begin
      state     <= state_n;
      out_valid <= (state_n == EMIT);
      error     <= accept && bad;
      if (accept && !bad) begin
        out_instr  <= word0;
        out_last   <= !two_word;
        pend_instr <= word1;
      end else if (state == EMIT && out_ready && !out_last) begin
        out_instr <= pend_instr;
        out_last  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder: a field-arithmetic reference model feeds a
// scoreboard checked every cycle, plus directed cases with literal expectations.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0, in_func7 = '0;
  logic [2:0]  in_func3 = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid, out_ready = 1'b1, out_last, error;
  logic [31:0] out_instr;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  instr_encoder #(.LI_COMPRESS(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_func3(in_func3), .in_func7(in_func7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_last(out_last), .error(error)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoder built from shifts and masks of the field values.
  function automatic void model_enc(input logic [2:0] fmt, input logic [6:0] op,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
      output int n, output logic [31:0] w0, output logic [31:0] w1, output bit bad);
    int unsigned uop, uf3, uf7, urd, urs1, urs2, uimm, hi, lo;
    uop = 32'(op); uf3 = 32'(f3); uf7 = 32'(f7); urd = 32'(rd);
    urs1 = 32'(rs1); urs2 = 32'(rs2); uimm = imm;
    n = 1; w0 = 0; w1 = 0; bad = 0;
    case (fmt)
      3'd0: w0 = (uf7 << 25) | (urs2 << 20) | (urs1 << 15) | (uf3 << 12) | (urd << 7) | uop;
      3'd1:
        if (uop == 32'h13 && (uf3 == 1 || uf3 == 5))
          w0 = (uf7 << 25) | ((uimm & 31) << 20) | (urs1 << 15) | (uf3 << 12) | (urd << 7) | uop;
        else
          w0 = ((uimm & 32'hFFF) << 20) | (urs1 << 15) | (uf3 << 12) | (urd << 7) | uop;
      3'd2: w0 = (((uimm >> 5) & 32'h7F) << 25) | (urs2 << 20) | (urs1 << 15) | (uf3 << 12)
                 | ((uimm & 31) << 7) | uop;
      3'd3: begin
        w0 = (((uimm >> 12) & 1) << 31) | (((uimm >> 5) & 32'h3F) << 25) | (urs2 << 20)
             | (urs1 << 15) | (uf3 << 12) | (((uimm >> 1) & 15) << 8)
             | (((uimm >> 11) & 1) << 7) | uop;
        bad = (uimm & 1) != 0;
      end
      3'd4: w0 = (uimm & 32'hFFFFF000) | (urd << 7) | uop;
      3'd5: begin
        w0 = (((uimm >> 20) & 1) << 31) | (((uimm >> 1) & 32'h3FF) << 21)
             | (((uimm >> 11) & 1) << 20) | (((uimm >> 12) & 32'hFF) << 12) | (urd << 7) | uop;
        bad = (uimm & 1) != 0;
      end
      3'd6: begin
        hi = (uimm + 32'h800) >> 12;
        lo = uimm & 32'hFFF;
        if (hi == 0) w0 = (lo << 20) | (urd << 7) | 32'h13;
        else if (lo == 0) w0 = (hi << 12) | (urd << 7) | 32'h37;
        else begin
          n  = 2;
          w0 = (hi << 12) | (urd << 7) | 32'h37;
          w1 = (lo << 20) | (urd << 15) | (urd << 7) | 32'h13;
        end
      end
      default: begin n = 0; bad = 1; end
    endcase
    if (bad) n = 0;
  endfunction

  // Scoreboard: expected words as {last, instr}, checked at the negedge.
  logic [32:0] expq[$];
  bit          err_pend = 0, hold_pend = 0, gap_ok = 0;
  logic [32:0] held = '0;

  always @(negedge clk) begin
    int n; logic [31:0] w0, w1; bit bad; logic [32:0] e;
    if (reset) begin
      expq.delete(); err_pend = 0; hold_pend = 0; gap_ok = 0;
    end else begin
      chk("error", 64'(error), 64'(err_pend));
      chk("in_ready", 64'(in_ready),
          64'((expq.size() == 0) || (expq.size() == 1 && out_valid && out_ready)));
      if (expq.size() == 0) chk("spurious_valid", 64'(out_valid), 64'(0));
      else if (!gap_ok)     chk("valid_cont", 64'(out_valid), 64'(1));
      if (hold_pend && out_valid) chk("hold", 64'({out_last, out_instr}), 64'(held));
      hold_pend = out_valid && !out_ready;
      held      = {out_last, out_instr};
      gap_ok    = 0;
      if (out_valid && out_ready && expq.size() > 0) begin
        e = expq.pop_front();
        chk("word", 64'({out_last, out_instr}), 64'(e));
        gap_ok = !e[32];
      end
      err_pend = 0;
      if (in_valid && in_ready) begin
        model_enc(in_fmt, in_opcode, in_func3, in_func7, in_rd, in_rs1, in_rs2, in_imm,
                  n, w0, w1, bad);
        err_pend = bad;
        if (n == 1) expq.push_back({1'b1, w0});
        if (n == 2) begin expq.push_back({1'b0, w0}); expq.push_back({1'b1, w1}); end
      end
    end
  end

  task automatic scramble();
    in_fmt = 3'($urandom); in_opcode = 7'($urandom); in_func3 = 3'($urandom);
    in_func7 = 7'($urandom); in_rd = 5'($urandom); in_rs1 = 5'($urandom);
    in_rs2 = 5'($urandom); in_imm = $urandom;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm);
    int k;
    @(posedge clk); #1;
    in_fmt = fmt; in_opcode = op; in_func3 = f3; in_func7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic exp_word(input string name, input logic [31:0] instr, input logic last);
    @(negedge clk);
    chk(name, 64'({out_valid, out_last, out_instr}), 64'({1'b1, last, instr}));
  endtask

  initial begin
    int n; logic [31:0] w0, w1; bit bad;

    // Pin the model with hand-derived encodings.
    model_enc(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, n, w0, w1, bad);
    chk("model_add", 64'(w0), 64'h002081B3);
    model_enc(3'd1, 7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'd3, n, w0, w1, bad);
    chk("model_srai", 64'(w0), 64'h4030D093);
    model_enc(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345FFF, n, w0, w1, bad);
    chk("model_li", 64'({n[1:0], w0, w1}), {2'd2, 32'h123462B7, 32'hFFF28293});
    model_enc(3'd6, 7'h00, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'hFFFFF800, n, w0, w1, bad);
    chk("model_li_wrap", 64'({n[1:0], w0}), {30'd0, 2'd1, 32'h80000113});

    // Reset state, then ready on the first cycle out of reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 64'({out_valid, out_last, error, in_ready, out_instr}), 64'(0));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(in_ready), 64'(1));

    send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0);
    exp_word("r_add", 32'h002081B3, 1'b1);
    send(3'd1, 7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'd3);
    exp_word("i_srai", 32'h4030D093, 1'b1);
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8);
    exp_word("b_beq", 32'h00208463, 1'b1);

    send(3'd6, 7'h7F, 3'd7, 7'h7F, 5'd5, 5'd9, 5'd9, 32'h12345FFF);
    exp_word("li_lui", 32'h123462B7, 1'b0);
    chk("li_ready_low", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("li_gap", 64'({out_valid, in_ready}), 64'(0));
    exp_word("li_addi", 32'hFFF28293, 1'b1);
    send(3'd6, 7'h00, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    exp_word("li_short", 32'h00500093, 1'b1);

    // Output stall with new requests offered.
    @(posedge clk); #1 out_ready = 1'b0;
    send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0);
    exp_word("stall_word", 32'h002081B3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      scramble(); in_fmt = 3'd0; in_valid = 1'b1;
      @(negedge clk);
      chk("stall_hold", 64'({out_valid, in_ready, out_instr}), {31'd0, 1'b1, 1'b0, 32'h002081B3});
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_drained", 64'(out_valid), 64'(0));

    // Rejected requests.
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd7);
    @(negedge clk);
    chk("b_odd_err", 64'({error, out_valid}), 64'(2));
    @(negedge clk);
    chk("b_odd_pulse", 64'({error, out_valid}), 64'(0));
    send(3'd7, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0);
    @(negedge clk);
    chk("fmt7_err", 64'({error, out_valid}), 64'(2));
    @(negedge clk);
    chk("fmt7_pulse", 64'({error, out_valid}), 64'(0));

    // Reset while the LUI of a pair is held.
    @(posedge clk); #1 out_ready = 1'b0;
    send(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    exp_word("rst_li_lui", 32'h123462B7, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_li_cleared", 64'({out_valid, in_ready}), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_no_addi", 64'(out_valid), 64'(0));
    end

    // Randomized traffic; scoreboard does the checking.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(0, 599) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      scramble();
      if ($urandom_range(0, 1) == 1) in_fmt = 3'd6;
      if (in_fmt == 3'd1 && $urandom_range(0, 1) == 1) in_opcode = 7'h13;
      if (in_fmt == 3'd6) begin
        case ($urandom_range(0, 3))
          0: in_imm = 32'($signed(12'($urandom)));
          1: in_imm = $urandom & 32'hFFFFF000;
          2: in_imm = 32'hFFFFF800 + 32'($urandom_range(0, 15));
          default: ;
        endcase
      end
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1; reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(expq.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter LI_COMPRESS, default 1, meaning LI requests whose value fits one instruction emit a single word.
REQ-002 SHALL have port CLK  input  1  rising-edge clock for all state.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset; one clock, synchronous active-high reset.
REQ-004 SHALL have port IN_VALID  input  1  request present.
REQ-005 SHALL have port IN_READY  output  1  request accepted when IN_VALID & IN_READY at a rising edge.
REQ-006 SHALL have port IN_FMT  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=LI pseudo-op, 7=illegal.
REQ-007 SHALL have ports IN_OPCODE  input  7, IN_FUNC3  input  3, IN_FUNC7  input  7, holding the instruction fields.
REQ-008 SHALL have ports IN_RD, IN_RS1, IN_RS2  input  5 each, holding the register indices.
REQ-009 SHALL have port IN_IMM  input  32  signed immediate or byte offset (U: full value, upper 20 bits used).
REQ-010 SHALL have port OUT_VALID  output  1, port OUT_READY  input  1, and port OUT_INSTR  output  32, holding the encoded word.
REQ-011 SHALL have port OUT_LAST  output  1, high on the final word of a request.
REQ-012 SHALL have port ERROR  output  1, a one-cycle pulse when a request is rejected.

Function
REQ-013 SHALL encode R as {FUNC7,RS2,RS1,FUNC3,RD,OPCODE}.
REQ-014 SHALL encode I as {IMM[11:0],RS1,FUNC3,RD,OPCODE}.
REQ-015 SHALL encode the I-format shift opcode 0010011 with FUNC3 001/101 as {FUNC7,IMM[4:0],RS1,FUNC3,RD,OPCODE}.
REQ-016 SHALL encode S as {IMM[11:5],RS2,RS1,FUNC3,IMM[4:0],OPCODE}.
REQ-017 SHALL encode B as {IMM[12],IMM[10:5],RS2,RS1,FUNC3,IMM[4:1],IMM[11],OPCODE}.
REQ-018 SHALL encode U as {IMM[31:12],RD,OPCODE}.
REQ-019 SHALL encode J as {IMM[20],IMM[10:1],IMM[11],IMM[19:12],RD,OPCODE}.
REQ-020 SHALL, for LI, ignore IN_OPCODE/FUNC fields and compute HI=(IMM+0x800)[31:12] with 32-bit wrap and LO=IMM[11:0].
REQ-021 SHALL, for LI, emit LUI RD,HI (opcode 0110111) then ADDI RD,RD,LO (opcode 0010011, FUNC3 000).
REQ-022 SHALL, for LI with LI_COMPRESS=1 and HI=0, emit only ADDI RD,x0,LO.
REQ-023 SHALL, for LI with LI_COMPRESS=1, HI!=0 and LO=0, emit only the LUI.
REQ-024 SHALL implement FSM states IDLE (output slot empty), EMIT (word held), EMIT2 (LI second word pending).
REQ-025 SHALL transition IDLE->EMIT on accept, and EMIT->IDLE on OUT_READY when OUT_LAST=1.
REQ-026 SHALL transition EMIT->EMIT2 on OUT_READY when OUT_LAST=0, loading the ADDI word.
REQ-027 SHALL transition EMIT2->EMIT on the next cycle, with OUT_VALID continuous across the pair except for that one load cycle.
REQ-028 SHALL register OUT_VALID/OUT_INSTR/OUT_LAST exactly 1 cycle after acceptance.
REQ-029 SHALL hold OUT_INSTR/OUT_LAST stable while OUT_VALID & !OUT_READY.
REQ-030 SHALL drive IN_READY = (state==IDLE) | (state==EMIT & OUT_LAST & OUT_READY), giving back-to-back single-word throughput of 1 per cycle.
REQ-031 SHALL reject FMT=7 and B/J requests with IMM[0]=1: accept, no output word, ERROR=1 the following cycle, state IDLE.
REQ-032 SHALL capture all IN_* fields on accept; later input changes SHALL NOT affect words in flight.
REQ-033 SHALL hold IN_READY low during EMIT2 and during EMIT with OUT_LAST=0.

Reset
REQ-034 SHALL, while RESET=1 at a clock edge, set state IDLE, OUT_VALID=0, OUT_INSTR=0, OUT_LAST=0, ERROR=0, IN_READY=0.
REQ-035 SHALL drive IN_READY=1 the first cycle after RESET deasserts.
REQ-036 SHALL, on reset mid-LI, discard the pending second word and emit no ADDI after reset.

Verification
REQ-037 SHALL pass: R ADD (OPCODE 0110011, FUNC3 0, FUNC7 0, RD 3, RS1 1, RS2 2) -> OUT_INSTR 0x002081B3, OUT_LAST=1, 1 cycle after accept.
REQ-038 SHALL pass: I SRAI (FUNC3 101, FUNC7 0100000, RD 1, RS1 1, IMM 3) -> 0x4030D093; then B BEQ (OPCODE 1100011, RS1 1, RS2 2, IMM 8) -> 0x00208463.
REQ-039 SHALL pass: LI RD 5, IMM 0x12345FFF -> 0x123462B7 (LAST=0) then 0xFFF28293 (LAST=1); LI RD 1, IMM 5 -> single 0x00500093.
REQ-040 SHALL pass: OUT_READY low 3 cycles with a word held -> OUT_INSTR unchanged, IN_READY=0, no input captured.
REQ-041 SHALL pass: B with IMM 7, and FMT 7 -> one ERROR pulse each, OUT_VALID never asserted.
REQ-042 SHALL pass: RESET asserted while LUI is held -> next cycle OUT_VALID=0, ADDI never appears.
